// File: rtl/core_pkg.sv
// Shared types for the writeback stage: source select, FSM states, load
// encodings and the context captured while a load is outstanding.
package core_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_e;

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_LOAD = 1'b1
  } wb_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef struct packed {
    logic [4:0] rd;
    logic       we;
    logic [2:0] funct3;
    logic [1:0] addr;
  } load_ctx_t;

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks byte/halfword out of the raw word,
// extends it, and flags illegal encodings and misaligned addresses.
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data,
  output logic            misaligned,
  output logic            illegal
);

  logic [XLEN-1:0] shifted;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  always_comb begin
    shifted  = word >> {addr, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    illegal    = 1'b0;
    misaligned = 1'b0;
    data       = word;
    case (funct3)
      LB:  data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU: data = {{(XLEN-8){1'b0}}, byte_sel};
      LH: begin
        data       = {{(XLEN-16){half_sel[15]}}, half_sel};
        misaligned = addr[0];
      end
      LHU: begin
        data       = {{(XLEN-16){1'b0}}, half_sel};
        misaligned = addr[0];
      end
      LW:      misaligned = (addr != 2'b00);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Writeback stage: registers the RF write port, holds upstream while a load
// response is outstanding, and pulses load_err_o on bad loads.
module mem_wb_stage
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            flush_i,
  input  logic [4:0]      rd_i,
  input  logic            regwrite_i,
  input  logic [1:0]      wb_sel_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic [2:0]      funct3_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] wd_o,
  output logic            regwrite_o,
  output logic            load_err_o
);

  wb_state_e       state;
  load_ctx_t       ctx;
  logic            accept;
  logic [2:0]      al_funct3;
  logic [1:0]      al_addr;
  logic [XLEN-1:0] al_data;
  logic            al_misaligned;
  logic            al_illegal;

  assign ready_o = (state == S_IDLE) && !reset_i;
  assign accept  = valid_i && ready_o && !flush_i;

  // One aligner serves both the accept-time check (incoming fields) and the
  // response formatting (latched fields); the state picks which.
  assign al_funct3 = (state == S_IDLE) ? funct3_i : ctx.funct3;
  assign al_addr   = (state == S_IDLE) ? alu_result_i[1:0] : ctx.addr;

  load_align #(.XLEN(XLEN)) u_align (
    .funct3     (al_funct3),
    .addr       (al_addr),
    .word       (dmem_rdata_i),
    .data       (al_data),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= S_IDLE;
      ctx        <= '0;
      rd_o       <= '0;
      wd_o       <= '0;
      regwrite_o <= 1'b0;
      load_err_o <= 1'b0;
    end else begin
      regwrite_o <= 1'b0;
      load_err_o <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          case (wb_sel_e'(wb_sel_i))
            WB_ALU, WB_PC4: if (regwrite_i && rd_i != 5'd0) begin
              rd_o       <= rd_i;
              wd_o       <= (wb_sel_i == WB_ALU) ? alu_result_i : pc_plus4_i;
              regwrite_o <= 1'b1;
            end
            WB_LOAD: begin
              if (al_misaligned || al_illegal) begin
                load_err_o <= 1'b1;
              end else begin
                ctx   <= '{rd: rd_i, we: regwrite_i, funct3: funct3_i,
                           addr: alu_result_i[1:0]};
                state <= S_WAIT_LOAD;
              end
            end
            default: ;
          endcase
        end
        S_WAIT_LOAD: begin
          // Flush beats a same-cycle response.
          if (flush_i) begin
            state <= S_IDLE;
          end else if (dmem_rvalid_i) begin
            state <= S_IDLE;
            if (ctx.we && ctx.rd != 5'd0) begin
              rd_o       <= ctx.rd;
              wd_o       <= al_data;
              regwrite_o <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic        flush_i;
  logic [4:0]  rd_i;
  logic        regwrite_i;
  logic [1:0]  wb_sel_i;
  logic [31:0] alu_result_i;
  logic [31:0] pc_plus4_i;
  logic [2:0]  funct3_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic [4:0]  rd_o;
  logic [31:0] wd_o;
  logic        regwrite_o;
  logic        load_err_o;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .flush_i       (flush_i),
    .rd_i          (rd_i),
    .regwrite_i    (regwrite_i),
    .wb_sel_i      (wb_sel_i),
    .alu_result_i  (alu_result_i),
    .pc_plus4_i    (pc_plus4_i),
    .funct3_i      (funct3_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rd_o          (rd_o),
    .wd_o          (wd_o),
    .regwrite_o    (regwrite_o),
    .load_err_o    (load_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic op(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                    input logic [31:0] alu, input logic [31:0] pc4, input logic [2:0] f3);
    valid_i = 1'b1; wb_sel_i = sel; rd_i = rd; regwrite_i = we;
    alu_result_i = alu; pc_plus4_i = pc4; funct3_i = f3;
  endtask

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; rd_i = '0; regwrite_i = 1'b0;
    wb_sel_i = '0; alu_result_i = '0; pc_plus4_i = '0; funct3_i = '0;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    tick(); tick();
    chk("rst_ready", 32'(ready_o), 0);
    chk("rst_rd", 32'(rd_o), 0);
    chk("rst_wd", wd_o, 0);
    chk("rst_we", 32'(regwrite_o), 0);
    chk("rst_err", 32'(load_err_o), 0);
    reset_i = 1'b0;
    #1 chk("post_rst_ready", 32'(ready_o), 1);

    // ALU then PC+4 back to back
    op(2'd0, 5'd5, 1'b1, 32'h0000_00AA, 32'h0, 3'd0);
    tick();
    chk("alu_we", 32'(regwrite_o), 1);
    chk("alu_rd", 32'(rd_o), 5);
    chk("alu_wd", wd_o, 32'hAA);
    chk("alu_ready", 32'(ready_o), 1);
    op(2'd2, 5'd1, 1'b1, 32'h0, 32'h104, 3'd0);
    tick();
    chk("pc4_we", 32'(regwrite_o), 1);
    chk("pc4_rd", 32'(rd_o), 1);
    chk("pc4_wd", wd_o, 32'h104);
    valid_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_5555;  // ignored in IDLE
    tick();
    dmem_rvalid_i = 1'b0;
    chk("idle_we", 32'(regwrite_o), 0);
    chk("hold_rd", 32'(rd_o), 1);
    chk("hold_wd", wd_o, 32'h104);

    // LB at 0x1003, response 3 cycles after accept
    op(2'd1, 5'd7, 1'b1, 32'h1003, 32'h0, 3'b000);
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall_ready", 32'(ready_o), 0);
      chk("lb_stall_we", 32'(regwrite_o), 0);
      if (i == 2) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FF_1234; end
      if (i < 2) tick();
    end
    tick();
    dmem_rvalid_i = 1'b0;
    chk("lb_we", 32'(regwrite_o), 1);
    chk("lb_rd", 32'(rd_o), 7);
    chk("lb_wd", wd_o, 32'hFFFF_FF80);
    chk("lb_ready", 32'(ready_o), 1);
    tick();
    chk("lb_once", 32'(regwrite_o), 0);

    // LHU / LH at 0x2002
    op(2'd1, 5'd8, 1'b1, 32'h2002, 32'h0, 3'b101);
    tick();
    valid_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hBEEF_0000;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("lhu_we", 32'(regwrite_o), 1);
    chk("lhu_wd", wd_o, 32'h0000_BEEF);
    op(2'd1, 5'd9, 1'b1, 32'h2002, 32'h0, 3'b001);
    tick();
    valid_i = 1'b0; dmem_rvalid_i = 1'b1;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("lh_rd", 32'(rd_o), 9);
    chk("lh_wd", wd_o, 32'hFFFF_BEEF);

    // misaligned LW, then illegal funct3
    op(2'd1, 5'd10, 1'b1, 32'h2002, 32'h0, 3'b010);
    tick();
    chk("lw_mis_err", 32'(load_err_o), 1);
    chk("lw_mis_we", 32'(regwrite_o), 0);
    chk("lw_mis_ready", 32'(ready_o), 1);
    op(2'd1, 5'd10, 1'b1, 32'h2000, 32'h0, 3'b011);
    tick();
    chk("ill_err", 32'(load_err_o), 1);
    op(2'd3, 5'd10, 1'b1, 32'h77, 32'h0, 3'b000);
    tick();
    chk("sel3_err", 32'(load_err_o), 0);
    chk("sel3_we", 32'(regwrite_o), 0);
    op(2'd1, 5'd10, 1'b1, 32'h2001, 32'h0, 3'b101);
    tick();
    chk("lhu_mis_err", 32'(load_err_o), 1);

    // rd=0 suppressed
    op(2'd0, 5'd0, 1'b1, 32'h1234, 32'h0, 3'd0);
    tick();
    chk("x0_we", 32'(regwrite_o), 0);
    chk("x0_wd_hold", wd_o, 32'hFFFF_BEEF);

    // flush with simultaneous response in WAIT_LOAD
    op(2'd1, 5'd10, 1'b1, 32'h3000, 32'h0, 3'b010);
    tick();
    valid_i = 1'b0; flush_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
    tick();
    flush_i = 1'b0; dmem_rvalid_i = 1'b0;
    chk("flush_we", 32'(regwrite_o), 0);
    chk("flush_ready", 32'(ready_o), 1);
    op(2'd0, 5'd11, 1'b1, 32'h55, 32'h0, 3'd0);
    tick();
    chk("after_flush_we", 32'(regwrite_o), 1);
    chk("after_flush_wd", wd_o, 32'h55);
    flush_i = 1'b1;
    op(2'd0, 5'd12, 1'b1, 32'h66, 32'h0, 3'd0);
    tick();
    flush_i = 1'b0;
    chk("idle_flush_we", 32'(regwrite_o), 0);
    chk("idle_flush_wd", wd_o, 32'h55);

    // reset during WAIT_LOAD
    op(2'd1, 5'd12, 1'b1, 32'h0, 32'h0, 3'b010);
    tick();
    valid_i = 1'b0;
    chk("wait_ready", 32'(ready_o), 0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEAD_BEEF;
    #1 chk("rst_wait_ready", 32'(ready_o), 1);
    tick();
    dmem_rvalid_i = 1'b0;
    chk("rst_wait_we", 32'(regwrite_o), 0);
    chk("rst_wait_rd", 32'(rd_o), 0);
    chk("rst_wait_wd", wd_o, 0);
    chk("rst_wait_err", 32'(load_err_o), 0);
    chk("rst_wait_ready2", 32'(ready_o), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
